data_memory_ls: RTL

Parametrised, byte-addressed data memory for the SEQ/PIPE RISC-V core. It is the load/store successor to the plain word-wide data_memory and supports:
- B/H/W/D access sizes with byte lanes;
- sign or zero extension on loads;
- misalignment detection;
- a registered 1-cycle read response with a valid/ready handshake;
- a reset sweep that zeroes every word, one word per cycle.

The core's MEM stage drives it directly.

---
 rtl/data_memory_pkg.sv | 21 ++
 rtl/data_memory_ls_load_extend.sv | 36 +++
 rtl/data_memory_ls.sv | 114 +++++++++++
 3 files changed

// File: rtl/data_memory_pkg.sv
// Shared encodings and helpers for the load/store data memory.
package data_memory_pkg;

    // Access size encodings carried on req_size
    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Controller state: sweeping memory to zero, or serving requests
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    // Number of bytes touched by an access of the given size
    function automatic logic [3:0] size_bytes(input logic [1:0] size);
        return 4'd1 << size;
    endfunction

endpackage

// File: rtl/data_memory_ls_load_extend.sv
// Extracts a B/H/W/D field from a memory word at a byte lane and
// right-aligns it, sign- or zero-extending to the full word width.
module load_extend
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int LW         = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] word,
    input  logic [LW-1:0]         lane,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    output logic [DATA_WIDTH-1:0] data
);

    logic [DATA_WIDTH-1:0] sh;
    logic                  msb;
    int                    n;

    // Shift the selected lane down to bit 0, then fill above the field
    always_comb begin
        sh = word >> {lane, 3'b000};
        n  = 8 << size;
        if (n > DATA_WIDTH) n = DATA_WIDTH;
        case (size)
            SZ_B:    msb = sh[7];
            SZ_H:    msb = sh[15];
            SZ_W:    msb = sh[31];
            default: msb = sh[DATA_WIDTH-1];
        endcase
        data = '0;
        for (int i = 0; i < DATA_WIDTH; i++)
            data[i] = (i < n) ? sh[i] : (msb & ~is_unsigned);
    end

endmodule

// File: rtl/data_memory_ls.sv
// Byte-addressed little-endian data memory with B/H/W/D loads and stores,
// misalignment faults, a registered 1-cycle response and a reset sweep.
module data_memory_ls
    import data_memory_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int ADDR_WIDTH     = 10,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    input  logic                  req_write,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    output logic                  ready,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] read_data,
    output logic                  misaligned
);

    localparam int NB    = DATA_WIDTH / 8;
    localparam int LW    = $clog2(NB);
    localparam int WIDX  = ADDR_WIDTH - LW;
    localparam int DEPTH = 1 << WIDX;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_t                state;
    logic [WIDX-1:0]       clear_ptr;

    logic [LW-1:0]         lane;
    logic [WIDX-1:0]       widx;
    logic [3:0]            szb;
    logic [2:0]            amask;
    logic                  mis;
    logic                  acc;
    logic [NB-1:0]         be;
    logic [DATA_WIDTH-1:0] wsh;
    logic [DATA_WIDTH-1:0] rd_word;
    logic [DATA_WIDTH-1:0] ext_data;

    assign lane    = addr[LW-1:0];
    assign widx    = addr[ADDR_WIDTH-1:LW];
    assign ready   = reset && (state == ST_IDLE);
    assign acc     = req_valid && ready;
    assign rd_word = mem[widx];

    // Decode alignment fault; a double access has no home on a 32-bit word
    always_comb begin
        szb   = size_bytes(req_size);
        amask = 3'(szb - 4'd1);
        mis   = (|(addr[2:0] & amask)) ||
                ((req_size == SZ_D) && (DATA_WIDTH == 32));
    end

    // Byte enables and lane-aligned store data for the merge
    always_comb begin
        be  = '0;
        wsh = write_data << {lane, 3'b000};
        for (int b = 0; b < NB; b++)
            if (b >= int'(lane) && b < int'(lane) + int'(szb)) be[b] = 1'b1;
    end

    load_extend #(
        .DATA_WIDTH(DATA_WIDTH),
        .LW        (LW)
    ) u_ext (
        .word       (rd_word),
        .lane       (lane),
        .size       (req_size),
        .is_unsigned(req_unsigned),
        .data       (ext_data)
    );

    // Memory array: sweep-zero after reset, otherwise merge accepted stores
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == ST_CLEAR) begin
                if (CLEAR_ON_RESET != 0) mem[clear_ptr] <= '0;
            end else if (acc && req_write && !mis) begin
                for (int b = 0; b < NB; b++)
                    if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
            end
        end
    end

    // Controller FSM and registered response
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= ST_CLEAR;
            clear_ptr  <= '0;
            rsp_valid  <= 1'b0;
            read_data  <= '0;
            misaligned <= 1'b0;
        end else begin
            rsp_valid  <= acc;
            misaligned <= acc && mis;
            read_data  <= (acc && !req_write && !mis) ? ext_data : '0;
            case (state)
                ST_CLEAR: begin
                    clear_ptr <= clear_ptr + 1'b1;
                    if (CLEAR_ON_RESET == 0 || clear_ptr == WIDX'(DEPTH - 1))
                        state <= ST_IDLE;
                end
                ST_IDLE:  state <= ST_IDLE;
                default:  state <= ST_CLEAR;
            endcase
        end
    end

endmodule
